stage3_pc_unit: RTL

- Producer side of the stage3 program-counter interface (pc_unit modport); owns the architectural PC register of every hart.
- Drives pc[] to fetch; accepts fetch's npc[] under per-hart enables; applies higher-priority redirects from execute/CSR.
- Round-robin scheduler picks which hart fetch services next, skipping halted harts.

---
 rtl/stage3_types_pkg.sv | 24 ++
 rtl/stage3_hart_scheduler.sv | 55 +++++
 rtl/stage3_pc_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/stage3_types_pkg.sv
// Shared types and constants for the stage3 program-counter unit.
// Hart-index width is derived from the hart count through hart_w().
package stage3_types_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam int unsigned MAX_HARTS        = 16;
  localparam int unsigned HART_IDX_W       = 4;

  // Widest hart index the unit supports.
  typedef logic [HART_IDX_W-1:0] hart_idx_t;

  // Source selected for one hart's PC register on the next edge.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_NPC,
    PC_REDIRECT
  } pc_sel_t;

  function automatic int unsigned hart_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stage3_hart_scheduler.sv
// Round-robin pointer that picks the hart fetch services next.
// Halted harts are skipped; with no runnable hart the pointer holds.
module stage3_hart_scheduler #(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned HART_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HARTS-1:0] hart_halt,
  input  logic                 fetch_adv,
  output logic [HART_W-1:0]    fetch_hart,
  output logic                 fetch_valid_c
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam int unsigned SUM_W = HART_W + 1;

  logic [HART_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0]  sum;
  logic              found;
  logic              advance;

  // Scan forward from ptr (wrapping) for the first runnable hart; offset
  // NUM_HARTS revisits ptr itself so a lone runnable hart keeps the slot.
  always_comb begin
    ptr_d   = ptr_q;
    sum     = '0;
    found   = 1'b0;
    advance = fetch_adv || hart_halt[ptr_q];
    if (advance) begin
      for (int off = 1; off <= int'(NUM_HARTS); off++) begin
        sum = {1'b0, ptr_q} + SUM_W'(off);
        if (sum >= SUM_W'(NUM_HARTS)) begin
          sum = sum - SUM_W'(NUM_HARTS);
        end
        if (!found && !hart_halt[HART_W'(sum)]) begin
          ptr_d = HART_W'(sum);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign fetch_hart    = ptr_q;
  assign fetch_valid_c = !rst && !hart_halt[ptr_q];

endmodule

// File: rtl/stage3_pc_unit.sv
// Architectural PC registers for every hart plus the fetch hart scheduler.
// Redirects from execute/CSR take priority over fetch's next-PC loads.
module stage3_pc_unit
  import stage3_types_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  localparam int unsigned HART_W   = hart_w(NUM_HARTS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_HARTS-1:0][31:0]  npc,
  input  logic [NUM_HARTS-1:0]        pc_en,
  input  logic                        redirect_valid,
  input  logic [HART_W-1:0]           redirect_hart,
  input  logic [31:0]                 redirect_pc,
  input  logic [NUM_HARTS-1:0]        hart_halt,
  input  logic                        fetch_adv,
  output logic [NUM_HARTS-1:0][31:0]  pc,
  output logic [HART_W-1:0]           fetch_hart,
  output logic                        fetch_valid,
  output logic                        redirect_misaligned
);

  logic redir_ok;
  logic misaligned_q, misaligned_d;

  // Out-of-range hart indices are possible when NUM_HARTS is not a power of two.
  always_comb begin
    redir_ok     = redirect_valid &&
                   ({1'b0, redirect_hart} < (HART_W + 1)'(NUM_HARTS));
    misaligned_d = redir_ok && (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign redirect_misaligned = misaligned_q;

  for (genvar h = 0; h < int'(NUM_HARTS); h++) begin : g_hart
    pc_sel_t     sel;
    logic [31:0] pc_q, pc_d;

    always_comb begin
      sel  = PC_HOLD;
      pc_d = pc_q;
      if (redir_ok && (redirect_hart == HART_W'(h))) begin
        sel = PC_REDIRECT;
      end else if (pc_en[h]) begin
        sel = PC_NPC;
      end
      unique case (sel)
        PC_REDIRECT: pc_d = redirect_pc & PC_ALIGN_MASK;
        PC_NPC:      pc_d = npc[h] & PC_ALIGN_MASK;
        default:     pc_d = pc_q;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        pc_q <= RESET_PC;
      end else begin
        pc_q <= pc_d;
      end
    end

    assign pc[h] = pc_q;
  end

  stage3_hart_scheduler #(
    .NUM_HARTS (NUM_HARTS),
    .HART_W    (HART_W)
  ) u_sched (
    .clk           (CLK),
    .rst           (RST),
    .hart_halt     (hart_halt),
    .fetch_adv     (fetch_adv),
    .fetch_hart    (fetch_hart),
    .fetch_valid_c (fetch_valid)
  );

endmodule
